// File: rtl/fifo_pac_overflow_pkg.sv
// Shared types and defaults for the PAC overflow FIFO drain path.
// Used by fifo_pac_overflow_drain and pac_skid_buf.
package fifo_pac_overflow_pkg;

  localparam int PAC_OVF_DATA_W     = 512;
  localparam int PAC_OVF_RD_LATENCY = 1;

  typedef logic [PAC_OVF_DATA_W-1:0] pac_ovf_data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } drain_state_e;

  function automatic int pac_ovf_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pac_skid_buf.sv
// pac_skid_buf: circular register FIFO with push/pop and occupancy.
// Head entry is presented on dout; contents clear on reset.
module pac_skid_buf
  import fifo_pac_overflow_pkg::*;
#(
  parameter int W     = PAC_OVF_DATA_W,
  parameter int DEPTH = 2,
  parameter int CW    = pac_ovf_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] occ
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (occ == CW'(DEPTH));
  assign empty   = (occ == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      unique case (1'b1)
        do_push && !do_pop: occ <= occ + CW'(1);
        do_pop && !do_push: occ <= occ - CW'(1);
        default:            occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_pac_overflow_drain.sv
// fifo_pac_overflow_drain: credit-limited read engine for the PAC overflow FIFO.
// Define FIFO_PAC_OVERFLOW_DRAIN_STATS_EN to build the beat/stall counters.
module fifo_pac_overflow_drain
  import fifo_pac_overflow_pkg::*;
#(
  parameter int DATA_W     = PAC_OVF_DATA_W,
  parameter int RD_LATENCY = PAC_OVF_RD_LATENCY,
  parameter int SKID_DEPTH = RD_LATENCY + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              drain_en,
  input  logic              fifo_rdempty,
  input  logic [DATA_W-1:0] fifo_q,
  output logic              fifo_rdreq,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              drain_idle,
  output logic [31:0]       beat_count,
  output logic [31:0]       stall_cycles
);

  localparam int OW = pac_ovf_cnt_w(SKID_DEPTH);
  localparam int CW =
    pac_ovf_cnt_w(SKID_DEPTH + RD_LATENCY + 1);

  drain_state_e          state;
  logic [RD_LATENCY-1:0] trk;
  logic [CW-1:0]         inflight;
  logic [OW-1:0]         occ;
  logic [CW-1:0]         committed;
  logic                  land;
  logic                  pop;
  logic                  credit;

  assign land      = trk[RD_LATENCY-1];
  assign m_valid   = (occ != '0);
  assign pop       = m_valid && m_ready;
  assign committed = inflight + CW'(occ) - CW'(pop);
  assign credit    = (committed < CW'(SKID_DEPTH));

  // Gated by reset_n so no read is issued into a discarded pipeline.
  assign fifo_rdreq = reset_n && (state == RUN) &&
                      drain_en && !fifo_rdempty && credit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      trk      <= '0;
      inflight <= '0;
    end else begin
      trk <= (trk << 1) | RD_LATENCY'(fifo_rdreq);
      unique case (1'b1)
        fifo_rdreq && !land: inflight <= inflight + CW'(1);
        land && !fifo_rdreq: inflight <= inflight - CW'(1);
        default:             inflight <= inflight;
      endcase
    end
  end

  pac_skid_buf #(
    .W     (DATA_W),
    .DEPTH (SKID_DEPTH),
    .CW    (OW)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (land),
    .din     (fifo_q),
    .pop     (pop),
    .dout    (m_data),
    .occ     (occ)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      drain_idle <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (drain_en) begin
            state      <= RUN;
            drain_idle <= 1'b0;
          end
        end
        RUN: begin
          if (!drain_en) begin
            state <= STOP;
          end
        end
        STOP: begin
          if (drain_en) begin
            state <= RUN;
          end else if (inflight == '0 && occ == '0) begin
            state      <= IDLE;
            drain_idle <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          drain_idle <= 1'b1;
        end
      endcase
    end
  end

`ifdef FIFO_PAC_OVERFLOW_DRAIN_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      beat_count   <= '0;
      stall_cycles <= '0;
    end else begin
      if (pop) begin
        beat_count <= beat_count + 32'd1;
      end
      if (m_valid && !m_ready && stall_cycles != '1) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end
`else
  assign beat_count   = '0;
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fifo_pac_overflow_drain.sv
// Scoreboard bench for fifo_pac_overflow_drain: latency 1 and latency 3.
// Behavioural FIFO models feed both instances; monitors check order.
module tb_fifo_pac_overflow_drain;

  localparam int W = 512;

`ifdef FIFO_PAC_OVERFLOW_DRAIN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;

  logic         en_a, blk_a, rdy_a, empty_a;
  logic [W-1:0] q_a, dat_a, st_a;
  logic         req_a, vld_a, idle_a;
  logic [31:0]  beats_a, stall_a;

  logic         en_b, blk_b, rdy_b, empty_b;
  logic [W-1:0] q_b, dat_b;
  logic [W-1:0] st_b [3];
  logic         req_b, vld_b, idle_b;
  logic [31:0]  beats_b, stall_b;

  logic [W-1:0] fq_a[$], sb_a[$];
  logic [W-1:0] fq_b[$], sb_b[$];
  int qn_a, qn_b;
  int nreq_a, npop_a, f_req_a, f_vld_a;
  int f_pop_a, l_pop_a, i_rise_a, mx_a;
  int nreq_b, npop_b, f_req_b, f_vld_b;
  int f_pop_b, l_pop_b, mx_b;
  bit pend_a, pend_b, idle_q_a;
  logic [15:0] lfsr;

  assign empty_a = (qn_a == 0) || blk_a;
  assign empty_b = (qn_b == 0) || blk_b;
  assign q_a     = st_a;
  assign q_b     = st_b[2];

  fifo_pac_overflow_drain #(
    .DATA_W(W), .RD_LATENCY(1), .SKID_DEPTH(2)
  ) dut_a (
    .clk(clk), .reset_n(reset_n),
    .drain_en(en_a), .fifo_rdempty(empty_a),
    .fifo_q(q_a), .fifo_rdreq(req_a),
    .m_valid(vld_a), .m_ready(rdy_a),
    .m_data(dat_a), .drain_idle(idle_a),
    .beat_count(beats_a), .stall_cycles(stall_a)
  );

  fifo_pac_overflow_drain #(
    .DATA_W(W), .RD_LATENCY(3), .SKID_DEPTH(4)
  ) dut_b (
    .clk(clk), .reset_n(reset_n),
    .drain_en(en_b), .fifo_rdempty(empty_b),
    .fifo_q(q_b), .fifo_rdreq(req_b),
    .m_valid(vld_b), .m_ready(rdy_b),
    .m_data(dat_b), .drain_idle(idle_b),
    .beat_count(beats_b), .stall_cycles(stall_b)
  );

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // FIFO models: a read seen at the edge lands RD_LATENCY cycles later.
  always begin
    @(posedge clk);
    #1;
    st_b[2] = st_b[1];
    st_b[1] = st_b[0];
    if (pend_a) begin
      chk("no_overread_a", fq_a.size() != 0, 1);
      if (fq_a.size() != 0) st_a = fq_a.pop_front();
      qn_a = fq_a.size();
    end
    if (pend_b) begin
      chk("no_overread_b", fq_b.size() != 0, 1);
      if (fq_b.size() != 0) st_b[0] = fq_b.pop_front();
      qn_b = fq_b.size();
    end
  end

  always @(negedge clk) begin
    if (nreq_a - npop_a > mx_a) mx_a = nreq_a - npop_a;
    pend_a = req_a;
    if (req_a) begin
      if (f_req_a < 0) f_req_a = cyc;
      nreq_a++;
    end
    if (vld_a && f_vld_a < 0) f_vld_a = cyc;
    if (idle_a && !idle_q_a) i_rise_a = cyc;
    idle_q_a = idle_a;
    if (vld_a && rdy_a) begin
      chk("sb_a_has_entry", sb_a.size() != 0, 1);
      if (sb_a.size() != 0)
        chk("data_a", dat_a, sb_a.pop_front());
      if (f_pop_a < 0) f_pop_a = cyc;
      l_pop_a = cyc;
      npop_a++;
    end
  end

  always @(negedge clk) begin
    if (nreq_b - npop_b > mx_b) mx_b = nreq_b - npop_b;
    pend_b = req_b;
    if (req_b) begin
      if (f_req_b < 0) f_req_b = cyc;
      nreq_b++;
    end
    if (vld_b && f_vld_b < 0) f_vld_b = cyc;
    if (vld_b && rdy_b) begin
      chk("sb_b_has_entry", sb_b.size() != 0, 1);
      if (sb_b.size() != 0)
        chk("data_b", dat_b, sb_b.pop_front());
      if (f_pop_b < 0) f_pop_b = cyc;
      l_pop_b = cyc;
      npop_b++;
    end
  end

  task automatic push_a(input logic [W-1:0] v);
    fq_a.push_back(v);
    sb_a.push_back(v);
    qn_a = fq_a.size();
  endtask

  task automatic push_b(input logic [W-1:0] v);
    fq_b.push_back(v);
    sb_b.push_back(v);
    qn_b = fq_b.size();
  endtask

  task automatic reset_all();
    reset_n = 1'b0;
    en_a = 0; rdy_a = 0; blk_a = 0;
    en_b = 0; rdy_b = 0; blk_b = 0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    fq_a.delete(); sb_a.delete(); qn_a = 0;
    fq_b.delete(); sb_b.delete(); qn_b = 0;
    nreq_a = 0; npop_a = 0; f_req_a = -1;
    f_vld_a = -1; f_pop_a = -1; l_pop_a = -1;
    i_rise_a = -1; mx_a = 0;
    nreq_b = 0; npop_b = 0; f_req_b = -1;
    f_vld_b = -1; f_pop_b = -1; l_pop_b = -1;
    mx_b = 0;
  endtask

  task automatic wait_drain(input bit b, input int lim,
                            input string nm);
    int n = 0;
    while ((b ? sb_b.size() : sb_a.size()) != 0
           && n < lim) begin
      tick();
      n++;
    end
    chk(nm, (b ? sb_b.size() : sb_a.size()) == 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    en_a = 0; rdy_a = 0; blk_a = 0;
    en_b = 0; rdy_b = 0; blk_b = 0;
    tick();
    tick();
    chk("rst_rdreq", req_a, 0);
    chk("rst_valid", vld_a, 0);
    chk("rst_data", dat_a, 0);
    chk("rst_idle", idle_a, 1);
    chk("rst_beats", beats_a, 0);
    chk("rst_stall", stall_a, 0);
    chk("rst_valid_b", vld_b, 0);
    chk("rst_idle_b", idle_b, 1);

    // Streaming 16 beats with continuous ready
    reset_all();
    for (int i = 1; i <= 16; i++) push_a(W'(i));
    rdy_a = 1; en_a = 1;
    wait_drain(0, 60, "t1_drained");
    chk("t1_latency", f_vld_a - f_req_a, 2);
    chk("t1_burst_span", l_pop_a - f_pop_a, 15);
    chk("t1_pops", npop_a, 16);
    chk("t1_beats", beats_a, STATS ? 16 : 0);

    // Backpressure: ready low for 20 valid cycles
    reset_all();
    for (int i = 1; i <= 8; i++) push_a(W'(i));
    en_a = 1;
    n = 0;
    while (!vld_a && n < 20) begin tick(); n++; end
    chk("t2_valid_seen", vld_a, 1);
    repeat (20) tick();
    chk("t2_reqs_held", nreq_a, 2);
    chk("t2_data_hold", dat_a, 1);
    chk("t2_valid_hold", vld_a, 1);
    chk("t2_stall", stall_a, STATS ? 20 : 0);
    rdy_a = 1;
    wait_drain(0, 60, "t2_drained");
    chk("t2_pops", npop_a, 8);
    chk("t2_reqs_total", nreq_a, 8);
    chk("t2_max_out", mx_a <= 2, 1);

    // drain_en dropped the cycle after the first read
    reset_all();
    for (int i = 0; i < 4; i++) push_a(W'(8'h31 + i));
    rdy_a = 1; en_a = 1;
    n = 0;
    while (nreq_a < 1 && n < 10) begin tick(); n++; end
    en_a = 0;
    n = cyc;
    for (int k = 0; k < 20 && i_rise_a < 0; k++) tick();
    chk("t3_idle_delay", i_rise_a - n, 3);
    chk("t3_one_req", nreq_a, 1);
    chk("t3_delivered", npop_a, 1);
    chk("t3_idle", idle_a, 1);
    repeat (4) tick();
    chk("t3_no_more_req", nreq_a, 1);

    // Empty toggling with pseudo-random ready
    reset_all();
    for (int i = 0; i < 12; i++) push_a(W'(12'h100 + i));
    en_a = 1;
    lfsr = 16'hACE1;
    for (int k = 0; k < 300 && sb_a.size() != 0; k++) begin
      blk_a = k[0];
      lfsr = {lfsr[14:0],
              lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      rdy_a = lfsr[0] | lfsr[5];
      tick();
    end
    rdy_a = 1; blk_a = 0;
    wait_drain(0, 40, "t4_drained");
    chk("t4_pops", npop_a, 12);
    chk("t4_max_out", mx_a <= 2, 1);

    // Reset with two beats buffered
    reset_all();
    for (int i = 0; i < 6; i++) push_a(W'(8'h51 + i));
    en_a = 1;
    repeat (6) tick();
    chk("t5_reqs", nreq_a, 2);
    chk("t5_valid_pre", vld_a, 1);
    reset_n = 0;
    tick();
    chk("t5_valid", vld_a, 0);
    chk("t5_rdreq", req_a, 0);
    chk("t5_data", dat_a, 0);
    chk("t5_beats", beats_a, 0);
    chk("t5_stall", stall_a, 0);
    chk("t5_idle", idle_a, 1);

    // Latency 3, depth 4 streaming
    reset_all();
    for (int i = 1; i <= 10; i++) push_b(W'(8'h60 + i));
    rdy_b = 1; en_b = 1;
    wait_drain(1, 80, "t6_drained");
    chk("t6_latency", f_vld_b - f_req_b, 4);
    chk("t6_burst_span", l_pop_b - f_pop_b, 9);
    chk("t6_pops", npop_b, 10);
    chk("t6_reqs", nreq_b, 10);
    chk("t6_beats", beats_b, STATS ? 10 : 0);
    chk("t6_stall", stall_b, 0);
    chk("t6_max_out", mx_b <= 4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_pac_overflow_drain.md
# fifo_pac_overflow_drain

Read-side drain engine for the 512-bit PAC overflow FIFO. Sits in the FIFO's read-clock domain, issues `rdreq` against `rdempty`, captures `q` after the FIFO's fixed read latency, and presents entries in order on a valid/ready stream toward the downstream consumer. An internal skid buffer sized to the read latency sustains one beat per cycle under continuous `m_ready`, and the engine never over-reads when the downstream applies backpressure.

## Interface
Parameters:
- `DATA_W`, 512, FIFO and stream data width.
- `RD_LATENCY`, 1, cycles from `rdreq` to valid `q` (normal, non-show-ahead mode); legal values 1..3.
- `SKID_DEPTH`, `RD_LATENCY+1`, skid buffer entries; must be ≥ `RD_LATENCY+1`.

Ports:
- `clk`  in  1  single clock; this is the overflow FIFO's `rdclk`.
- `reset_n`  in  1  synchronous, active-low reset.
- `drain_en`  in  1  permits new FIFO reads.
- `fifo_rdempty`  in  1  FIFO empty flag.
- `fifo_q`  in  DATA_W  FIFO read data.
- `fifo_rdreq`  out  1  FIFO read request.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  stream consumer ready.
- `m_data`  out  DATA_W  stream data.
- `drain_idle`  out  1  no reads in flight and skid buffer empty.
- `beat_count`  out  32  beats delivered (stats).
- `stall_cycles`  out  32  backpressure cycles (stats).

## Operation
- Credit rule: `fifo_rdreq = drain_en && !fifo_rdempty && (inflight + occupancy - pop) < SKID_DEPTH`. Here `pop = m_valid && m_ready`, and `inflight` counts reads issued but not yet landed.
- Landing: a shift register of depth `RD_LATENCY` tracks issued reads. When a tracked read emerges, `fifo_q` is written into the skid buffer that cycle.
- The skid buffer is a circular register FIFO. The head drives `m_data`; `m_valid = occupancy != 0`.
- Order: strict FIFO order; no drop or duplication.
- Simultaneous landing and pop: both take effect, and occupancy is unchanged.
- Hold rule: `m_data` and `m_valid` hold stable while `m_valid && !m_ready`.
- State machine:
  - IDLE: `drain_idle=1`; moves to RUN when `drain_en=1`.
  - RUN: reads issued per the credit rule; moves to STOP when `drain_en` falls.
  - STOP: no new reads; in-flight reads still land and buffered beats are still delivered. Moves to IDLE when `inflight==0 && occupancy==0`. Moves back to RUN if `drain_en` rises first.
- `drain_idle` is asserted only in IDLE.
- Reset values: `fifo_rdreq=0`, `m_valid=0`, `m_data=0`, `drain_idle=1`, state IDLE, `inflight=0`, `occupancy=0`, both counters 0.
- Reset mid-operation: in-flight and buffered entries are discarded. Those entries are lost from the FIFO; the system reset owner accepts this loss.
- `fifo_rdempty` high: no rdreq. Entries already in flight still land.

## Timing
- `fifo_rdreq` is combinational from registered state plus `fifo_rdempty`, `drain_en` and `m_ready`.
- Latency: rdreq in cycle t → `fifo_q` sampled at end of cycle t+RD_LATENCY → `m_valid` in cycle t+RD_LATENCY+1. With RD_LATENCY=1 this is 2 cycles.
- Throughput: 1 beat/cycle with `m_ready` held high and the FIFO non-empty.
- Backpressure: once `m_ready` drops, at most `SKID_DEPTH` entries are held. `fifo_rdreq` stays low until a pop frees credit, and the buffer never overflows.

## Configuration
- `FIFO_PAC_OVERFLOW_DRAIN_STATS_EN`
- Defined:
  - `beat_count` increments on every pop and wraps at 2^32.
  - `stall_cycles` increments each cycle with `m_valid && !m_ready` and saturates at 0xFFFF_FFFF.
  - Both counters clear on reset.
- Undefined: the counter logic is absent and both ports are tied to 0. The port list is unchanged.

## Structure
- Package `fifo_pac_overflow_pkg`:
  - `PAC_OVF_DATA_W = 512`
  - typedef `pac_ovf_data_t` (logic [511:0])
  - state enum `drain_state_e` {IDLE, RUN, STOP}
  - `PAC_OVF_RD_LATENCY = 1`
- Sub-module `pac_skid_buf`: parameterised register FIFO with push/pop/occupancy. The drain top holds the FSM, the latency tracker, credit logic and stats.

## Test plan
- Preload 16 beats (0x1..0x10), `drain_en=1`, `m_ready=1` → `m_data` sequence 0x1..0x10 on 16 consecutive cycles. First `m_valid` 2 cycles after first rdreq; `beat_count=16`.
- 8 beats preloaded, `m_ready=0` for 20 cycles → exactly `SKID_DEPTH`=2 rdreqs issued, `m_data` holds 0x1, `stall_cycles=20`. Release `m_ready` → remaining beats arrive in order, no loss.
- `drain_en` dropped the cycle after a rdreq → that beat is delivered, state passes STOP→IDLE, and `drain_idle=1` 3 cycles later with no further rdreq.
- `fifo_rdempty` toggled every other cycle with random `m_ready` (seeded) → output order matches input order and occupancy never exceeds 2.
- `reset_n` asserted with 2 beats buffered → next cycle `m_valid=0`, `fifo_rdreq=0`, counters 0, state IDLE.
- RD_LATENCY=3, SKID_DEPTH=4, continuous `m_ready` → 1 beat/cycle sustained, with first `m_valid` 4 cycles after first rdreq.
